// File: rtl/multi_tick_timer_if.sv
// Control and status bundle for multi_tick_timer: per-channel run/mode/clear
// controls in, tick counts and strobes out.
interface multi_tick_timer_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 17
);
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       mode;
  logic [N_CH-1:0]       clear;
  logic [N_CH*CNT_W-1:0] ticks;
  logic [N_CH-1:0]       tick_pulse;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       wrap_pulse;

  modport master (
    output start, mode, clear,
    input  ticks, tick_pulse, done, wrap_pulse
  );

  modport slave (
    input  start, mode, clear,
    output ticks, tick_pulse, done, wrap_pulse
  );
endinterface

// File: rtl/multi_tick_timer.sv
// Multi-channel tick timer: each channel prescales clk by CLK_FREQ/TICK_RATE
// and counts ticks up to MAX_TICKS, either saturating or wrapping.
module multi_tick_timer #(
  parameter int CLK_FREQ  = 25000000,
  parameter int TICK_RATE = 1000,
  parameter int N_CH      = 4,
  parameter int MAX_TICKS = 96000,
  parameter int CNT_W     = 17
) (
  input logic               clk,
  input logic               rst,
  multi_tick_timer_if.slave bus
);
  localparam int DIV   = CLK_FREQ / TICK_RATE;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TICKS);

  logic [N_CH*CNT_W-1:0] ticks_vec;
  logic [N_CH-1:0]       tick_vec;
  logic [N_CH-1:0]       done_vec;
  logic [N_CH-1:0]       wrap_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PRE_W-1:0] pre_reg, pre_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             tick_reg, tick_next;
      logic             wrap_reg, wrap_next;
      logic             done_reg, done_next;

      always_comb begin
        pre_next  = pre_reg;
        cnt_next  = cnt_reg;
        tick_next = 1'b0;
        wrap_next = 1'b0;
        if (!bus.start[gi] || bus.clear[gi]) begin
          pre_next = '0;
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX && !bus.mode[gi]) begin
          // Saturated: park the prescaler so a later switch to wrap mode
          // waits a full tick period before wrapping.
          pre_next = '0;
        end else if (pre_reg == PRE_LAST) begin
          pre_next  = '0;
          tick_next = 1'b1;
          if (cnt_reg == CNT_MAX) begin
            cnt_next  = '0;
            wrap_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          pre_next = pre_reg + 1'b1;
        end
        done_next = bus.start[gi] && !bus.clear[gi] && !bus.mode[gi] &&
                    (cnt_next == CNT_MAX);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pre_reg  <= '0;
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
          wrap_reg <= 1'b0;
          done_reg <= 1'b0;
        end else begin
          pre_reg  <= pre_next;
          cnt_reg  <= cnt_next;
          tick_reg <= tick_next;
          wrap_reg <= wrap_next;
          done_reg <= done_next;
        end
      end

      assign ticks_vec[gi*CNT_W +: CNT_W] = cnt_reg;
      assign tick_vec[gi] = tick_reg;
      assign done_vec[gi] = done_reg;
      assign wrap_vec[gi] = wrap_reg;
    end
  endgenerate

  assign bus.ticks      = ticks_vec;
  assign bus.tick_pulse = tick_vec;
  assign bus.done       = done_vec;
  assign bus.wrap_pulse = wrap_vec;
endmodule

// File: tb/tb_multi_tick_timer.sv
// Randomized and directed checks of multi_tick_timer against a cycle-level
// behavioural model of the per-channel tick rules (DIV=10, MAX_TICKS=3).
module tb_multi_tick_timer;
  localparam int CLK_FREQ  = 100;
  localparam int TICK_RATE = 10;
  localparam int DIV       = CLK_FREQ / TICK_RATE;
  localparam int N_CH      = 2;
  localparam int MAX_TICKS = 3;
  localparam int CNT_W     = 4;
  localparam int VEC_W     = N_CH*CNT_W + 3*N_CH;

  logic clk;
  logic rst;
  multi_tick_timer_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

  multi_tick_timer #(
    .CLK_FREQ(CLK_FREQ), .TICK_RATE(TICK_RATE), .N_CH(N_CH),
    .MAX_TICKS(MAX_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles elapsed in the current tick period and the tick count.
  int m_el  [N_CH];
  int m_cnt [N_CH];
  bit m_tick[N_CH];
  bit m_wrap[N_CH];
  bit m_done[N_CH];

  logic [VEC_W-1:0] dut_vec;
  assign dut_vec = {bus.ticks, bus.tick_pulse, bus.done, bus.wrap_pulse};

  function automatic logic [VEC_W-1:0] model_vec();
    logic [N_CH*CNT_W-1:0] t;
    logic [N_CH-1:0] p, d, w;
    for (int ch = 0; ch < N_CH; ch++) begin
      t[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
      p[ch] = m_tick[ch];
      d[ch] = m_done[ch];
      w[ch] = m_wrap[ch];
    end
    return {t, p, d, w};
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge,
  // then return 1 time unit later so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    for (int ch = 0; ch < N_CH; ch++) begin
      m_tick[ch] = 1'b0;
      m_wrap[ch] = 1'b0;
      m_done[ch] = 1'b0;
      if (rst || !bus.start[ch] || bus.clear[ch]) begin
        m_el[ch]  = 0;
        m_cnt[ch] = 0;
      end else begin
        if (!(m_cnt[ch] == MAX_TICKS && bus.mode[ch] == 1'b0)) begin
          m_el[ch]++;
          if (m_el[ch] == DIV) begin
            m_el[ch]   = 0;
            m_tick[ch] = 1'b1;
            if (m_cnt[ch] == MAX_TICKS) begin
              m_cnt[ch]  = 0;
              m_wrap[ch] = 1'b1;
            end else begin
              m_cnt[ch]++;
            end
          end
        end
        m_done[ch] = (m_cnt[ch] == MAX_TICKS) && (bus.mode[ch] == 1'b0);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = '0;
    bus.clear = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int waited;
    $display("test_reset");
    rst = 1'b1;
    bus.start = 2'b11;
    bus.mode  = 2'b00;
    bus.clear = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== {VEC_W{1'b0}}) begin
        n_bad++;
        $display("FAIL reset_state cycle %0d: got %h want 0", i, dut_vec);
      end
    end
    rst = 1'b0;
    waited = 0;
    for (int i = 1; i <= 30 && waited == 0; i++) begin
      step();
      if (bus.tick_pulse[0] === 1'b1) waited = i;
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL reset_model cycle %0d: got %h want %h", i, dut_vec, model_vec());
      end
    end
    n_cmp++;
    if (waited !== 10) begin
      n_bad++;
      $display("FAIL reset_first_tick: got %0d cycles want 10", waited);
    end
    $display("  first tick after reset release at cycle %0d", waited);
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp;
    $display("test_saturate");
    do_reset();
    bus.mode  = 2'b00;
    bus.start = 2'b01;
    for (int k = 0; k < 45; k++) begin
      step();
      exp = (k >= 29) ? 4'd3 : (k >= 19) ? 4'd2 : (k >= 9) ? 4'd1 : 4'd0;
      n_cmp++;
      if (bus.ticks[CNT_W-1:0] !== exp ||
          bus.tick_pulse[0] !== (k == 9 || k == 19 || k == 29) ||
          bus.done[0] !== (k >= 29) || bus.wrap_pulse[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL saturate edge %0d: got cnt=%0d tp=%b done=%b wp=%b want cnt=%0d",
                 k, bus.ticks[CNT_W-1:0], bus.tick_pulse[0], bus.done[0],
                 bus.wrap_pulse[0], exp);
      end
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL saturate_model edge %0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] exp;
    $display("test_wrap");
    do_reset();
    bus.mode  = 2'b10;
    bus.start = 2'b10;
    for (int k = 0; k < 55; k++) begin
      step();
      exp = CNT_W'(((k + 1) / DIV) % (MAX_TICKS + 1));
      n_cmp++;
      if (bus.ticks[2*CNT_W-1:CNT_W] !== exp ||
          bus.tick_pulse[1] !== ((k + 1) % DIV == 0) ||
          bus.wrap_pulse[1] !== (k == 39) || bus.done[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap edge %0d: got cnt=%0d tp=%b wp=%b done=%b want cnt=%0d",
                 k, bus.ticks[2*CNT_W-1:CNT_W], bus.tick_pulse[1],
                 bus.wrap_pulse[1], bus.done[1], exp);
      end
    end
  endtask

  task automatic test_stop_clear();
    int waited;
    $display("test_stop_clear");
    do_reset();
    bus.mode  = 2'b00;
    bus.start = 2'b01;
    for (int k = 0; k < 15; k++) step();
    bus.start = 2'b00;
    step();
    n_cmp++;
    if (bus.ticks[CNT_W-1:0] !== 4'd0 || bus.tick_pulse[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_clears: got cnt=%0d tp=%b want 0", bus.ticks[CNT_W-1:0], bus.tick_pulse[0]);
    end
    bus.start = 2'b01;
    waited = 0;
    for (int i = 1; i <= 30 && waited == 0; i++) begin
      step();
      if (bus.tick_pulse[0] === 1'b1) waited = i;
    end
    n_cmp++;
    if (waited !== 10 || bus.ticks[CNT_W-1:0] !== 4'd1) begin
      n_bad++;
      $display("FAIL restart_tick: got %0d cycles cnt=%0d want 10 cycles cnt=1",
               waited, bus.ticks[CNT_W-1:0]);
    end
    for (int k = 0; k < 9; k++) step();
    bus.clear = 2'b01;
    step();
    n_cmp++;
    if (bus.ticks[CNT_W-1:0] !== 4'd0 || bus.tick_pulse[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_on_tick: got cnt=%0d tp=%b want cnt=0 tp=0",
               bus.ticks[CNT_W-1:0], bus.tick_pulse[0]);
    end
    n_cmp++;
    if (dut_vec !== model_vec()) begin
      n_bad++;
      $display("FAIL clear_model: got %h want %h", dut_vec, model_vec());
    end
    bus.clear = 2'b00;
    waited = 0;
    for (int i = 1; i <= 30 && waited == 0; i++) begin
      step();
      if (bus.tick_pulse[0] === 1'b1) waited = i;
    end
    n_cmp++;
    if (waited !== 10) begin
      n_bad++;
      $display("FAIL clear_next_tick: got %0d cycles want 10", waited);
    end
  endtask

  task automatic test_independence();
    logic [CNT_W-1:0] exp0, exp1;
    $display("test_independence");
    do_reset();
    bus.mode  = 2'b10;
    bus.start = 2'b01;
    for (int k = 0; k < 50; k++) begin
      if (k == 4) bus.start = 2'b11;
      step();
      exp0 = CNT_W'(((k + 1) / DIV > MAX_TICKS) ? MAX_TICKS : (k + 1) / DIV);
      exp1 = (k >= 4) ? CNT_W'(((k - 3) / DIV) % (MAX_TICKS + 1)) : 4'd0;
      n_cmp++;
      if (bus.ticks !== {exp1, exp0}) begin
        n_bad++;
        $display("FAIL independence edge %0d: got %h want %h", k, bus.ticks, {exp1, exp0});
      end
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL independence_model edge %0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== {VEC_W{1'b0}}) begin
      n_bad++;
      $display("FAIL midrun_reset: got %h want 0", dut_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    $display("test_random");
    do_reset();
    bus.start = 2'b11;
    bus.mode  = 2'($urandom_range(0, 3));
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        bus.start[ch] = ($urandom_range(0, 39) != 0);
        bus.clear[ch] = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 99) == 0) bus.mode[ch] = ~bus.mode[ch];
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h want %h", k, dut_vec, model_vec());
      end
      if (bus.tick_pulse != 0)
        $display("  cycle %0d tick=%b wrap=%b done=%b ticks=%h",
                 k, bus.tick_pulse, bus.wrap_pulse, bus.done, bus.ticks);
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      m_el[ch] = 0; m_cnt[ch] = 0;
      m_tick[ch] = 0; m_wrap[ch] = 0; m_done[ch] = 0;
    end
    rst = 1'b1;
    bus.start = '0;
    bus.mode  = '0;
    bus.clear = '0;
    test_reset();
    test_saturate();
    test_wrap();
    test_stop_clear();
    test_independence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multi_tick_timer.md
# multi_tick_timer

Multi-channel, parametrised successor to the single-channel tick counter used by the LCD/button front end. Each channel divides the system clock down to a programmable tick rate and counts elapsed ticks while its `start` level is held. Each channel runs in either saturating (one-shot) or wrapping (periodic) mode and provides tick strobes and done/wrap flags for downstream FSMs such as LCD refresh, debounce and timeouts.

## Interface
- `CLK_FREQ`, 25000000: system clock frequency in Hz.
- `TICK_RATE`, 1000: tick frequency in Hz. `DIV = CLK_FREQ / TICK_RATE` (integer division), must be ≥ 1.
- `N_CH`, 4: number of independent channels, ≥ 1.
- `MAX_TICKS`, 96000: terminal count, ≥ 1.
- `CNT_W`, 17: tick counter width, must be ≥ `$clog2(MAX_TICKS+1)`.
- `clk  in  1`: system clock. All logic updates on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `start  in  N_CH`: per-channel run level. 1 = count; 0 = channel idle and cleared.
- `mode  in  N_CH`: per-channel mode. 0 = saturate at `MAX_TICKS`; 1 = wrap to 0 after `MAX_TICKS`.
- `clear  in  N_CH`: per-channel synchronous restart pulse.
- `ticks  out  N_CH*CNT_W`: tick counts. Channel i occupies `[i*CNT_W +: CNT_W]`.
- `tick_pulse  out  N_CH`: one-cycle strobe, high on the cycle a channel's count changes because of a tick.
- `done  out  N_CH`: saturate mode only. High while the count equals `MAX_TICKS`.
- `wrap_pulse  out  N_CH`: wrap mode only. One-cycle strobe on the wrap from `MAX_TICKS` to 0.

## Operation
- Each channel has a prescaler (`$clog2(DIV)` bits, minimum 1) and a tick counter (`CNT_W` bits). Channels share nothing except `clk` and `rst`.
- Priority per channel, highest first: `rst` > `start`=0 > `clear` > tick advance.
- `rst`=1: all prescalers, counters and outputs go to 0 on the next edge.
- `start`=0: prescaler and counter are set to 0. `tick_pulse`, `wrap_pulse` and `done` are 0.
- `start`=1 and `clear`=1: prescaler and counter are set to 0. No strobe fires that cycle. Counting resumes on the next cycle.
- `start`=1 with no clear: the prescaler counts 0 to `DIV-1`. On the cycle it equals `DIV-1`, it returns to 0 and a tick event occurs. This gives exactly `DIV` clocks per tick; the earlier off-by-one of `DIV+1` is not carried forward.
- Tick event when count < `MAX_TICKS`: count += 1 and `tick_pulse` fires.
- Tick event when count = `MAX_TICKS`:
  - Saturate mode: count holds, the prescaler freezes at 0, no `tick_pulse`, `done` stays 1.
  - Wrap mode: count becomes 0, and both `tick_pulse` and `wrap_pulse` fire.
- `mode` is sampled every cycle. A change takes effect at the next tick event. For example, a saturated channel switched to wrap mode resumes prescaling and wraps after `DIV` cycles.
- `ticks` is the counter register itself. There is no extra output pipeline stage.

## Timing
- Reset values: `ticks`=0, `tick_pulse`=0, `done`=0, `wrap_pulse`=0 for all channels.
- Let `start` first be sampled high at edge E0.
  - First increment (`ticks`=1, `tick_pulse`=1) is visible after edge E0+`DIV-1`.
  - The n-th increment is visible after edge E0+`n*DIV-1`.
- `done` is registered. It rises on the same edge as the increment to `MAX_TICKS` and falls on the edge at which `start`=0, `clear` or `rst` is sampled.
- `start` deasserted mid-count: `ticks` reads 0 after the next edge. Partial prescaler progress is discarded.
- `clear` and the tick event in the same cycle: clear wins; count becomes 0 with no strobe.
- `rst` asserted mid-operation: rst wins over every other input on that edge.

## Test plan
All scenarios use `CLK_FREQ`=100, `TICK_RATE`=10 (`DIV`=10), `MAX_TICKS`=3, `N_CH`=2, `CNT_W`=4.
- **Reset.** Hold `rst` for 3 cycles with `start`=2'b11. Required: `ticks`=0 and all flags 0; the first tick lands 10 cycles after `rst` is released.
- **Saturate.** Channel 0, `mode`=0, `start` held. Required: `ticks`=1, 2, 3 after edges 9, 19 and 29 from start. `done`=1 from edge 29 onward, count stays at 3, no `tick_pulse` after edge 29.
- **Wrap.** Channel 1, `mode`=1. Required: counts 1, 2, 3, 0, 1… at 10-cycle spacing; `wrap_pulse` high for exactly one cycle at edge 39; `done` never asserts.
- **Stop and clear.** Drop `start` at cycle 15, then reassert it. Required: `ticks`=0 after the next edge and the next tick lands exactly 10 cycles after reassertion. Separately, pulse `clear` on the cycle a tick is due. Required: count becomes 0, no `tick_pulse`, next tick 10 cycles later.
- **Channel independence.** Start channel 0 at cycle 0 and channel 1 at cycle 4, with opposite modes. Required: each channel follows its own schedule offset by 4 cycles, and `rst` mid-run clears both on the same edge.
